// File: rtl/ysyx_24070014_bus_pkg.sv
// Shared constants and types for the bus arbiter: state encoding, default widths,
// and the index-width helper used by the arbiter and its round-robin picker.
package ysyx_24070014_bus_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_REQ  = 2'b01;
  localparam logic [1:0] ST_RESP = 2'b10;

  localparam int DEF_ADDR_LEN = 32;
  localparam int DEF_DATA_LEN = 32;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_REQ  = ST_REQ,
    S_RESP = ST_RESP
  } bus_state_e;

  // A single requester still needs a 1-bit index so that port widths stay legal.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ysyx_24070014_rr_picker.sv
// Combinational round-robin picker: one-hot grant to the first requester found
// in circular order, starting at i_last+1.
module ysyx_24070014_rr_picker
  import ysyx_24070014_bus_pkg::*;
#(
  parameter int NR_MASTER = 2,
  parameter int IW        = idx_w(NR_MASTER)
) (
  input  logic [NR_MASTER-1:0] i_req,
  input  logic [IW-1:0]        i_last,
  output logic [NR_MASTER-1:0] o_grant
);

  logic          w_found;
  logic [IW-1:0] w_idx;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 1; k <= NR_MASTER; k++) begin
      w_idx = IW'((int'(i_last) + k) % NR_MASTER);
      if (!w_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ysyx_24070014_bus_arbiter.sv
// Round-robin arbiter sharing one slave port among NR_MASTER requesters, locked
// to one owner from request acceptance until the response handshake.
//   state  | meaning
//   S_IDLE | no owner; pick next requester after r_last
//   S_REQ  | owner's request steered to the slave, waiting for s_req_ready
//   S_RESP | waiting for the slave response to reach the owner
module ysyx_24070014_bus_arbiter
  import ysyx_24070014_bus_pkg::*;
#(
  parameter int NR_MASTER = 2,
  parameter int ADDR_LEN  = DEF_ADDR_LEN,
  parameter int DATA_LEN  = DEF_DATA_LEN
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NR_MASTER-1:0]            m_req_valid,
  output logic [NR_MASTER-1:0]            m_req_ready,
  input  logic [NR_MASTER*ADDR_LEN-1:0]   m_req_addr,
  input  logic [NR_MASTER-1:0]            m_req_wen,
  input  logic [NR_MASTER*DATA_LEN-1:0]   m_req_wdata,
  input  logic [NR_MASTER*DATA_LEN/8-1:0] m_req_wmask,
  output logic [NR_MASTER-1:0]            m_resp_valid,
  input  logic [NR_MASTER-1:0]            m_resp_ready,
  output logic [DATA_LEN-1:0]             m_resp_rdata,
  output logic                            s_req_valid,
  input  logic                            s_req_ready,
  output logic [ADDR_LEN-1:0]             s_req_addr,
  output logic                            s_req_wen,
  output logic [DATA_LEN-1:0]             s_req_wdata,
  output logic [DATA_LEN/8-1:0]           s_req_wmask,
  input  logic                            s_resp_valid,
  output logic                            s_resp_ready,
  input  logic [DATA_LEN-1:0]             s_resp_rdata,
  output logic [NR_MASTER-1:0]            grant,
  output logic                            busy
);

  localparam int IW = idx_w(NR_MASTER);
  localparam int MW = DATA_LEN / 8;

  bus_state_e           r_state;
  logic [NR_MASTER-1:0] r_grant;
  logic [IW-1:0]        r_last;

  logic [NR_MASTER-1:0] w_next;
  logic [IW-1:0]        w_gidx;
  logic                 w_sel_valid;
  logic                 w_sel_resp_ready;
  logic [ADDR_LEN-1:0]  w_addr;
  logic                 w_wen;
  logic [DATA_LEN-1:0]  w_wdata;
  logic [MW-1:0]        w_wmask;
  logic                 w_in_req;
  logic                 w_in_resp;

  ysyx_24070014_rr_picker #(
    .NR_MASTER (NR_MASTER),
    .IW        (IW)
  ) u_picker (
    .i_req   (m_req_valid),
    .i_last  (r_last),
    .o_grant (w_next)
  );

  // One-hot keyed steering: only the granted master's fields can reach the slave.
  always_comb begin
    w_gidx           = '0;
    w_sel_valid      = 1'b0;
    w_sel_resp_ready = 1'b0;
    w_addr           = '0;
    w_wen            = 1'b0;
    w_wdata          = '0;
    w_wmask          = '0;
    for (int i = 0; i < NR_MASTER; i++) begin
      if (r_grant[i]) begin
        w_gidx           = IW'(i);
        w_sel_valid      = m_req_valid[i];
        w_sel_resp_ready = m_resp_ready[i];
        w_addr           = m_req_addr[i*ADDR_LEN +: ADDR_LEN];
        w_wen            = m_req_wen[i];
        w_wdata          = m_req_wdata[i*DATA_LEN +: DATA_LEN];
        w_wmask          = m_req_wmask[i*MW +: MW];
      end
    end
  end

  assign w_in_req  = (r_state == S_REQ);
  assign w_in_resp = (r_state == S_RESP);

  assign s_req_valid  = w_in_req & w_sel_valid;
  assign s_req_addr   = w_in_req ? w_addr  : '0;
  assign s_req_wen    = w_in_req & w_wen;
  assign s_req_wdata  = w_in_req ? w_wdata : '0;
  assign s_req_wmask  = w_in_req ? w_wmask : '0;
  assign m_req_ready  = (w_in_req & s_req_ready) ? r_grant : '0;
  assign m_resp_valid = (w_in_resp & s_resp_valid) ? r_grant : '0;
  assign s_resp_ready = w_in_resp & w_sel_resp_ready;
  assign m_resp_rdata = s_resp_rdata;
  assign grant        = r_grant;
  assign busy         = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_last  <= IW'(NR_MASTER - 1);
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|m_req_valid) begin
            r_grant <= w_next;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          // Owner withdrew before acceptance: drop the lock without moving r_last.
          if (!w_sel_valid) begin
            r_grant <= '0;
            r_state <= S_IDLE;
          end else if (s_req_ready) begin
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          if (s_resp_valid && w_sel_resp_ready) begin
            r_last  <= w_gidx;
            r_grant <= '0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_grant <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24070014_bus_arbiter.sv
// Bench for the bus arbiter: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a transaction-level model.
module tb_ysyx_24070014_bus_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  m_req_valid, m_req_ready, m_req_wen, m_resp_valid, m_resp_ready, grant;
  logic [63:0] m_req_addr, m_req_wdata;
  logic [7:0]  m_req_wmask;
  logic [31:0] m_resp_rdata;
  logic        s_req_valid, s_req_ready, s_req_wen, s_resp_valid, s_resp_ready, busy;
  logic [31:0] s_req_addr, s_req_wdata, s_resp_rdata;
  logic [3:0]  s_req_wmask;

  ysyx_24070014_bus_arbiter #(.NR_MASTER(2), .ADDR_LEN(32), .DATA_LEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_addr(m_req_addr),
    .m_req_wen(m_req_wen), .m_req_wdata(m_req_wdata), .m_req_wmask(m_req_wmask),
    .m_resp_valid(m_resp_valid), .m_resp_ready(m_resp_ready), .m_resp_rdata(m_resp_rdata),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_addr(s_req_addr),
    .s_req_wen(s_req_wen), .s_req_wdata(s_req_wdata), .s_req_wmask(s_req_wmask),
    .s_resp_valid(s_resp_valid), .s_resp_ready(s_resp_ready), .s_resp_rdata(s_resp_rdata),
    .grant(grant), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: owner index (-1 none), phase (0 idle, 1 request offered, 2 awaiting response), last winner.
  int mo    = -1;
  int mph   = 0;
  int mlast = 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mo = -1; mph = 0; mlast = 1;
  endtask

  task automatic compare_model();
    logic [1:0]  eg;
    logic [31:0] ea, ed;
    logic [3:0]  em;
    logic        ew, ev;
    eg = '0; ea = '0; ed = '0; em = '0; ew = 1'b0; ev = 1'b0;
    if (mo >= 0) eg[mo] = 1'b1;
    if (mph == 1) begin
      ea = m_req_addr[mo*32 +: 32];
      ed = m_req_wdata[mo*32 +: 32];
      em = m_req_wmask[mo*4 +: 4];
      ew = m_req_wen[mo];
      ev = m_req_valid[mo];
    end
    chk("grant", grant, eg);
    chk("busy", busy, mph != 0);
    chk("s_req_valid", s_req_valid, ev);
    chk("s_req_addr", s_req_addr, ea);
    chk("s_req_wdata", s_req_wdata, ed);
    chk("s_req_wmask", s_req_wmask, em);
    chk("s_req_wen", s_req_wen, ew);
    chk("m_req_ready", m_req_ready, (mph == 1 && s_req_ready) ? eg : 2'b00);
    chk("m_resp_valid", m_resp_valid, (mph == 2 && s_resp_valid) ? eg : 2'b00);
    chk("s_resp_ready", s_resp_ready, (mph == 2) ? m_resp_ready[mo] : 1'b0);
    if (mph == 2 && s_resp_valid) chk("m_resp_rdata", m_resp_rdata, s_resp_rdata);
  endtask

  // Advance the model with the inputs that the coming rising edge will sample.
  task automatic model_update();
    if (!rst_n) begin
      model_reset();
    end else if (mph == 0) begin
      for (int k = 1; k <= 2; k++) begin
        if (mph == 0 && m_req_valid[(mlast + k) % 2]) begin
          mo  = (mlast + k) % 2;
          mph = 1;
        end
      end
    end else if (mph == 1) begin
      if (!m_req_valid[mo]) begin
        mo = -1; mph = 0;
      end else if (s_req_ready) begin
        mph = 2;
      end
    end else begin
      if (s_resp_valid && m_resp_ready[mo]) begin
        mlast = mo; mo = -1; mph = 0;
      end
    end
  endtask

  task automatic step();
    #1;
    compare_model();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m_req_valid = '0; m_req_wen = '0; m_req_addr = '0; m_req_wdata = '0; m_req_wmask = '0;
    m_resp_ready = '0; s_req_ready = 1'b0; s_resp_valid = 1'b0; s_resp_rdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    clear_inputs();
    step();
    step();
    rst_n = 1'b1;
  endtask

  logic [1:0] exp_g [4];

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    #1;
    chk("reset_grant", grant, 2'b00);
    chk("reset_busy", busy, 1'b0);
    chk("reset_s_req_valid", s_req_valid, 1'b0);
    chk("reset_m_req_ready", m_req_ready, 2'b00);
    step();
    step();
    rst_n = 1'b1;

    // Single master, zero-wait slave.
    m_req_valid = 2'b01; m_req_addr[31:0] = 32'h8000_0000;
    s_req_ready = 1'b1; s_resp_valid = 1'b1; s_resp_rdata = 32'hDEAD_BEEF; m_resp_ready = 2'b11;
    #1; chk("single_idle_grant", grant, 2'b00);
    step();
    #1; chk("single_grant", grant, 2'b01);
    chk("single_addr", s_req_addr, 32'h8000_0000);
    step();
    m_req_valid = 2'b00;
    #1; chk("single_resp_valid", m_resp_valid, 2'b01);
    chk("single_rdata", m_resp_rdata, 32'hDEAD_BEEF);
    step();
    #1; chk("single_busy_done", busy, 1'b0);

    // Contention from reset: grants alternate starting with master 0.
    do_reset();
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
    m_req_valid = 2'b11; s_req_ready = 1'b1; s_resp_valid = 1'b1; m_resp_ready = 2'b11;
    m_req_addr = 64'h0000_2000_0000_1000;
    for (int t = 0; t < 4; t++) begin
      step();
      #1; chk("contention_grant", grant, exp_g[t]);
      step();
      step();
    end

    // Lock: master 1 must wait through a long response from master 0.
    do_reset();
    m_req_valid = 2'b11; s_req_ready = 1'b1; m_resp_ready = 2'b11;
    step();
    step();
    for (int c = 0; c < 5; c++) begin
      #1; chk("lock_grant", grant, 2'b01);
      chk("lock_ready1", m_req_ready[1], 1'b0);
      step();
    end
    s_resp_valid = 1'b1;
    step();
    s_resp_valid = 1'b0;
    step();
    #1; chk("lock_next_grant", grant, 2'b10);

    // Request backpressure then response stall.
    do_reset();
    m_req_valid = 2'b01; m_req_wen = 2'b01; m_req_addr[31:0] = 32'h0000_1000;
    m_req_wdata[31:0] = 32'h1234_5678; m_req_wmask[3:0] = 4'b1111; m_resp_ready = 2'b00;
    step();
    for (int c = 0; c < 3; c++) begin
      #1; chk("bp_valid", s_req_valid, 1'b1);
      chk("bp_wdata", s_req_wdata, 32'h1234_5678);
      chk("bp_wmask", s_req_wmask, 4'b1111);
      chk("bp_addr", s_req_addr, 32'h0000_1000);
      step();
    end
    s_req_ready = 1'b1;
    #1; chk("bp_accept", m_req_ready, 2'b01);
    step();
    m_req_valid = 2'b00; s_req_ready = 1'b0; s_resp_valid = 1'b1; s_resp_rdata = 32'hCAFE_0001;
    for (int c = 0; c < 2; c++) begin
      #1; chk("stall_s_resp_ready", s_resp_ready, 1'b0);
      chk("stall_busy", busy, 1'b1);
      step();
    end
    m_resp_ready = 2'b01;
    #1; chk("stall_release", s_resp_ready, 1'b1);
    step();
    #1; chk("stall_done_busy", busy, 1'b0);

    // Asynchronous reset in the middle of a response wait.
    do_reset();
    m_req_valid = 2'b10; s_req_ready = 1'b1; s_resp_valid = 1'b0; m_resp_ready = 2'b11;
    step();
    step();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("areset_grant", grant, 2'b00);
    chk("areset_busy", busy, 1'b0);
    chk("areset_s_req_valid", s_req_valid, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_req_valid = 2'b11;
    step();
    #1; chk("areset_priority", grant, 2'b01);

    // Randomized traffic with occasional protocol-violating withdrawals.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (mph == 1 && mo == i) m_req_valid[i] = ($urandom_range(15) != 0);
        else                     m_req_valid[i] = $urandom_range(1);
      end
      m_req_addr   = {$urandom, $urandom};
      m_req_wdata  = {$urandom, $urandom};
      m_req_wmask  = 8'($urandom);
      m_req_wen    = 2'($urandom);
      m_resp_ready = 2'($urandom);
      s_req_ready  = $urandom_range(1);
      s_resp_valid = $urandom_range(1);
      s_resp_rdata = $urandom;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
